// File: rtl/eccop_tzs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eccop_tzs_pkg
// Purpose  : Shared state encoding and width helpers for the trailing-zero
//            stripper.
// Revision : 1.0 - initial release
// ============================================================================
package eccop_tzs_pkg;

  typedef enum logic [1:0] {
    TZS_IDLE  = 2'd0,
    TZS_SHIFT = 2'd1,
    TZS_DONE  = 2'd2
  } tzs_state_t;

  function automatic int tzs_width(input int width_log2);
    return 1 << width_log2;
  endfunction

  function automatic int tzs_step(input int step_log2);
    return 1 << step_log2;
  endfunction

  function automatic int tzs_cnt_w(input int width_log2);
    return width_log2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tz_step.sv
`default_nettype none
// ============================================================================
// Module   : tz_step
// Purpose  : Combinational trailing-zero count of an S-bit slice, saturating
//            at S when the slice is all zeros.
// Revision : 1.0 - initial release
// ============================================================================
module tz_step
  import eccop_tzs_pkg::*;
#(
  parameter int P_STEP_LOG2 = 4
) (
  input  logic [tzs_step(P_STEP_LOG2)-1:0] i_d,
  output logic [P_STEP_LOG2:0]             o_t
);

  localparam int c_s  = tzs_step(P_STEP_LOG2);
  localparam int c_tw = P_STEP_LOG2 + 1;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    o_t = c_tw'(c_s);
    for (int i = c_s - 1; i >= 0; i--) begin
      if (i_d[i]) o_t = c_tw'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tz_strip_seq.sv
`default_nettype none
// ============================================================================
// Module   : tz_strip_seq
// Purpose  : Multi-cycle trailing-zero stripper, at most S bits per cycle.
//            Optional shift limit port enabled by macro TZS_SHIFT_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tz_strip_seq
  import eccop_tzs_pkg::*;
#(
  parameter int P_WIDTH_LOG2 = 8,
  parameter int P_STEP_LOG2  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(1<<P_WIDTH_LOG2)-1:0]   in_d,
`ifdef TZS_SHIFT_LIMIT_EN
  input  logic [P_WIDTH_LOG2:0]          in_lim,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [(1<<P_WIDTH_LOG2)-1:0]   out_d,
  output logic [P_WIDTH_LOG2:0]          out_c,
  output logic                           out_zero
);

  localparam int c_w  = tzs_width(P_WIDTH_LOG2);
  localparam int c_s  = tzs_step(P_STEP_LOG2);
  localparam int c_cw = tzs_cnt_w(P_WIDTH_LOG2);
  localparam logic [c_cw-1:0] c_w_cnt = c_cw'(c_w);
  localparam logic [c_cw-1:0] c_s_cnt = c_cw'(c_s);

  tzs_state_t        r_state, w_state_nxt;
  logic [c_w-1:0]    r_d, w_d_nxt, w_d_shift;
  logic [c_cw-1:0]   r_c, w_c_nxt, w_c_add, w_tl, w_zero_cnt;
  logic              r_zero, w_zero_nxt, w_step_done, w_lim_zero;
  logic [P_STEP_LOG2:0] w_t;

  tz_step #(.P_STEP_LOG2(P_STEP_LOG2)) u_step (
    .i_d (r_d[c_s-1:0]),
    .o_t (w_t)
  );

`ifdef TZS_SHIFT_LIMIT_EN
  logic [c_cw-1:0] r_lim, w_lim_nxt, w_rem;
  // Never step past the remaining limit budget.
  assign w_rem       = r_lim - r_c;
  assign w_tl        = (c_cw'(w_t) < w_rem) ? c_cw'(w_t) : w_rem;
  assign w_step_done = (w_tl < c_s_cnt) || (w_c_add == r_lim);
  assign w_zero_cnt  = (in_lim < c_w_cnt) ? in_lim : c_w_cnt;
  assign w_lim_zero  = (in_lim == '0);
`else
  assign w_tl        = c_cw'(w_t);
  assign w_step_done = (w_tl < c_s_cnt);
  assign w_zero_cnt  = c_w_cnt;
  assign w_lim_zero  = 1'b0;
`endif

  assign w_d_shift = r_d >> w_tl;
  assign w_c_add   = r_c + w_tl;

  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_c_nxt     = r_c;
    w_zero_nxt  = r_zero;
`ifdef TZS_SHIFT_LIMIT_EN
    w_lim_nxt   = r_lim;
`endif
    in_ready    = (r_state == TZS_IDLE) && !rst;
    out_valid   = (r_state == TZS_DONE);
    case (r_state)
      TZS_IDLE: begin
        if (in_valid && in_ready) begin
          w_d_nxt    = in_d;
          w_c_nxt    = '0;
          w_zero_nxt = (in_d == '0);
`ifdef TZS_SHIFT_LIMIT_EN
          w_lim_nxt  = in_lim;
`endif
          // A zero operand is resolved here so SHIFT always terminates.
          if (in_d == '0) begin
            w_d_nxt     = '0;
            w_c_nxt     = w_zero_cnt;
            w_state_nxt = TZS_DONE;
          end else if (in_d[0] || w_lim_zero) begin
            w_state_nxt = TZS_DONE;
          end else begin
            w_state_nxt = TZS_SHIFT;
          end
        end
      end
      TZS_SHIFT: begin
        w_d_nxt = w_d_shift;
        w_c_nxt = w_c_add;
        if (w_step_done) w_state_nxt = TZS_DONE;
      end
      TZS_DONE: begin
        if (out_ready) w_state_nxt = TZS_IDLE;
      end
      default: w_state_nxt = TZS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TZS_IDLE;
      r_d     <= '0;
      r_c     <= '0;
      r_zero  <= 1'b0;
`ifdef TZS_SHIFT_LIMIT_EN
      r_lim   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
      r_c     <= w_c_nxt;
      r_zero  <= w_zero_nxt;
`ifdef TZS_SHIFT_LIMIT_EN
      r_lim   <= w_lim_nxt;
`endif
    end
  end

  assign out_d    = r_d;
  assign out_c    = r_c;
  assign out_zero = r_zero;

endmodule
`default_nettype wire
